// File: rtl/branch_predict_resolve_pkg.sv
// Shared types and helpers for the branch prediction/resolution unit.
package bp_pkg;

  // 2-bit saturating counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Branch record carried from ID into EX
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
  } bp_rec_t;

  // Saturating counter step toward the actual outcome
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == ST) ? ST : ctr + 2'b01;
    end else begin
      res = (ctr == SNT) ? SNT : ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Pipeline-side signal bundle of the branch prediction/resolution unit.
interface branch_predict_resolve_if;

  logic        id_beq;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic        stall;
  logic        ex_resolve;
  logic        ex_taken;
  logic        id_prediction;
  logic        wrong_prediction;
  logic        prediction;
  logic [31:0] PC_beq;
  logic [31:0] immData_beq;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  // Pipeline side: drives ID/EX information, receives mux controls
  modport master (
    output id_beq, id_pc, id_imm, stall, ex_resolve, ex_taken,
    input  id_prediction, wrong_prediction, prediction, PC_beq, immData_beq,
           branch_count, mispredict_count
  );

  // Predictor side
  modport slave (
    input  id_beq, id_pc, id_imm, stall, ex_resolve, ex_taken,
    output id_prediction, wrong_prediction, prediction, PC_beq, immData_beq,
           branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_predict_resolve_bht.sv
// Branch history table of 2-bit saturating counters: async read, sync update.
module bht_2bit
  import bp_pkg::*;
#(
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  // Lookup returns the stored value; a same-cycle update is not bypassed
  assign rd_ctr = ctr_q[rd_idx];

  // Next value per entry: only the addressed counter moves
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ctr_d[i] = ctr_q[i];
      if (wr_en && (wr_idx == IDX_BITS'(i))) begin
        ctr_d[i] = sat_update(ctr_q[i], wr_taken);
      end
    end
  end

  // Counter storage, all entries return to the initial bias on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= ctr_d[i];
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Predicts beq direction in ID, tracks the branch into EX and reports
// mispredictions plus the recorded PC/offset for fetch correction.
module branch_predict_resolve
  import bp_pkg::*;
#(
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_predict_resolve_if.slave  bus
);

  bp_rec_t     rec_q, rec_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;

  logic [1:0]  rd_ctr;
  logic        id_pred;
  logic        resolve_fire;
  logic        wrong;
  logic        unused_pc_bits;

  // Only the word-index bits of the PCs address the table
  assign unused_pc_bits = ^{bus.id_pc[31:IDX_BITS+2], bus.id_pc[1:0],
                            rec_q.pc[31:IDX_BITS+2], rec_q.pc[1:0]};

  // A resolve with no live record is ignored entirely
  assign resolve_fire = rec_q.valid & bus.ex_resolve;
  assign wrong        = resolve_fire & (bus.ex_taken != rec_q.pred);
  assign id_pred      = bus.id_beq & rd_ctr[1];

  bht_2bit #(
    .IDX_BITS (IDX_BITS),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (bus.id_pc[IDX_BITS+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (resolve_fire),
    .wr_idx   (rec_q.pc[IDX_BITS+1:2]),
    .wr_taken (bus.ex_taken)
  );

  // Record load/consume and statistics next-state
  always_comb begin
    rec_d         = rec_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (!bus.stall) begin
      // The instruction in ID sits on the wrong path after a mispredict
      rec_d.valid = bus.id_beq & ~wrong;
      rec_d.pc    = bus.id_pc;
      rec_d.imm   = bus.id_imm;
      rec_d.pred  = id_pred;
    end else if (resolve_fire) begin
      // A held record must not resolve again on later stalled cycles
      rec_d.valid = 1'b0;
    end
    if (resolve_fire) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
      if (wrong) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
  end

  // ID->EX record and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      rec_q         <= rec_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.id_prediction    = id_pred;
  assign bus.wrong_prediction = wrong;
  assign bus.prediction       = rec_q.pred;
  assign bus.PC_beq           = rec_q.pc;
  assign bus.immData_beq      = rec_q.imm;
  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Table-driven bench for branch_predict_resolve with a scoreboard queue.
module tb_branch_predict_resolve;

  logic clk;
  logic rst_n;

  branch_predict_resolve_if bus ();

  branch_predict_resolve #(
    .IDX_BITS (4),
    .CTR_INIT (2'b01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        beq;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        stall;
    logic        res;
    logic        tk;
    logic        e_idp;
    logic        e_wrong;
    logic        e_pred;
    logic [31:0] e_pcb;
    logic [31:0] e_imm;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
  } vec_t;

  typedef struct {
    logic        idp;
    logic        wrong;
    logic        pred;
    logic [31:0] pcb;
    logic [31:0] imm;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  vec_t vecs [19];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic beq, input logic [31:0] pc, input logic [31:0] imm,
                       input logic stall, input logic res, input logic tk);
    bus.id_beq     = beq;
    bus.id_pc      = pc;
    bus.id_imm     = imm;
    bus.stall      = stall;
    bus.ex_resolve = res;
    bus.ex_taken   = tk;
  endtask

  // Pop the oldest expectation and compare every observable output
  task automatic compare_front(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty actual=0 required=1", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".id_prediction"},    {31'd0, bus.id_prediction},    {31'd0, e.idp});
    check({tag, ".wrong_prediction"}, {31'd0, bus.wrong_prediction}, {31'd0, e.wrong});
    check({tag, ".prediction"},       {31'd0, bus.prediction},       {31'd0, e.pred});
    check({tag, ".PC_beq"},           bus.PC_beq,                    e.pcb);
    check({tag, ".immData_beq"},      bus.immData_beq,               e.imm);
    check({tag, ".branch_count"},     {16'd0, bus.branch_count},     {16'd0, e.bc});
    check({tag, ".mispredict_count"}, {16'd0, bus.mispredict_count}, {16'd0, e.mc});
    $display("txn %s beq=%0d pc=0x%0h stall=%0d res=%0d tk=%0d -> idp=%0d wrong=%0d pred=%0d pcb=0x%0h bc=%0d mc=%0d",
             tag, bus.id_beq, bus.id_pc, bus.stall, bus.ex_resolve, bus.ex_taken,
             bus.id_prediction, bus.wrong_prediction, bus.prediction, bus.PC_beq,
             bus.branch_count, bus.mispredict_count);
  endtask

  function automatic exp_t mk_exp(input logic idp, input logic wrong, input logic pred,
                                  input logic [31:0] pcb, input logic [31:0] imm,
                                  input logic [15:0] bc, input logic [15:0] mc);
    exp_t e;
    e.idp = idp; e.wrong = wrong; e.pred = pred; e.pcb = pcb;
    e.imm = imm; e.bc = bc; e.mc = mc;
    return e;
  endfunction

  function automatic vec_t v(input logic beq, input logic [31:0] pc, input logic [31:0] imm,
                             input logic stall, input logic res, input logic tk,
                             input logic idp, input logic wrong, input logic pred,
                             input logic [31:0] pcb, input logic [31:0] eimm,
                             input logic [15:0] bc, input logic [15:0] mc);
    vec_t r;
    r.beq = beq; r.pc = pc; r.imm = imm; r.stall = stall; r.res = res; r.tk = tk;
    r.e_idp = idp; r.e_wrong = wrong; r.e_pred = pred; r.e_pcb = pcb;
    r.e_imm = eimm; r.e_bc = bc; r.e_mc = mc;
    return r;
  endfunction

  initial begin
    //            beq pc     imm    st res tk  idp wr pr pcb    imm    bc mc
    vecs[0]  = v(1, 32'h40, 32'h10, 0, 0, 0,   0, 0, 0, 32'h0,  32'h0,  0, 0); // NT predicted
    vecs[1]  = v(0, 32'h40, 32'h10, 0, 1, 1,   0, 1, 0, 32'h40, 32'h10, 0, 0); // mispredict
    vecs[2]  = v(1, 32'h40, 32'h10, 0, 0, 0,   1, 0, 0, 32'h40, 32'h10, 1, 1); // ctr now WT
    vecs[3]  = v(0, 32'h40, 32'h10, 0, 1, 1,   0, 0, 1, 32'h40, 32'h10, 1, 1); // correct
    vecs[4]  = v(1, 32'h40, 32'h10, 0, 0, 0,   1, 0, 0, 32'h40, 32'h10, 2, 1); // ctr ST
    vecs[5]  = v(0, 32'h40, 32'h10, 0, 1, 1,   0, 0, 1, 32'h40, 32'h10, 2, 1); // saturate
    vecs[6]  = v(1, 32'h40, 32'h10, 0, 0, 0,   1, 0, 0, 32'h40, 32'h10, 3, 1);
    vecs[7]  = v(0, 32'h40, 32'h10, 0, 1, 0,   0, 1, 1, 32'h40, 32'h10, 3, 1); // ST->WT
    vecs[8]  = v(1, 32'h40, 32'h10, 0, 0, 0,   1, 0, 0, 32'h40, 32'h10, 4, 2); // still T
    vecs[9]  = v(0, 32'h40, 32'h10, 0, 1, 0,   0, 1, 1, 32'h40, 32'h10, 4, 2); // WT->WNT
    vecs[10] = v(1, 32'h40, 32'h10, 0, 0, 0,   0, 0, 0, 32'h40, 32'h10, 5, 3);
    vecs[11] = v(1, 32'h44, 32'h20, 0, 1, 1,   0, 1, 0, 32'h40, 32'h10, 5, 3); // squash 0x44
    vecs[12] = v(0, 32'h44, 32'h20, 0, 1, 1,   0, 0, 0, 32'h44, 32'h20, 6, 4); // ignored
    vecs[13] = v(1, 32'h44, 32'h20, 0, 0, 0,   0, 0, 0, 32'h44, 32'h20, 6, 4); // idx1 untouched
    vecs[14] = v(0, 32'h48, 32'h30, 1, 1, 0,   0, 0, 0, 32'h44, 32'h20, 6, 4); // stall+resolve
    vecs[15] = v(0, 32'h48, 32'h30, 1, 1, 0,   0, 0, 0, 32'h44, 32'h20, 7, 4); // consumed
    vecs[16] = v(0, 32'h48, 32'h30, 1, 1, 1,   0, 0, 0, 32'h44, 32'h20, 7, 4); // no 2nd resolve
    vecs[17] = v(0, 32'h48, 32'h30, 0, 0, 0,   0, 0, 0, 32'h44, 32'h20, 7, 4);
    vecs[18] = v(1, 32'h44, 32'h20, 0, 0, 0,   0, 0, 0, 32'h48, 32'h30, 7, 4); // idx1 SNT

    rst_n = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].beq, vecs[i].pc, vecs[i].imm, vecs[i].stall, vecs[i].res, vecs[i].tk);
      sb_q.push_back(mk_exp(vecs[i].e_idp, vecs[i].e_wrong, vecs[i].e_pred, vecs[i].e_pcb,
                            vecs[i].e_imm, vecs[i].e_bc, vecs[i].e_mc));
      #1;
      compare_front($sformatf("v%0d", i));
      @(negedge clk);
    end

    // Reset lands between capture of 0x40 (ctr WT) and its taken resolve
    drive(1, 32'h40, 32'h10, 0, 0, 0);
    @(negedge clk);
    drive(0, 32'h40, 32'h10, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(mk_exp(0, 0, 0, 32'h0, 32'h0, 0, 0));
    compare_front("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h40, 32'h10, 0, 1, 1);
    sb_q.push_back(mk_exp(0, 0, 0, 32'h0, 32'h0, 0, 0));
    #1;
    compare_front("post_rst");
    @(negedge clk);
    // Record at 0x40 (predicted NT from the re-initialised counter) resolves taken
    drive(0, 32'h40, 32'h10, 0, 1, 1);
    sb_q.push_back(mk_exp(0, 1, 0, 32'h40, 32'h10, 0, 0));
    #1;
    compare_front("post_rst_res");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
